// File: rtl/cpu_trace_streamer_pkg.sv
// Shared definitions for the CPU commit-trace streamer.
//   - frame constants (sync byte, bytes per record)
//   - trace_rec_t: one buffered commit record (103 bits)
//   - trace_state_t: serializer FSM encoding
//   - pack_frame(): lays a record out as the 14-byte wire frame, MSB first
package cpu_trace_pkg;

    localparam logic [7:0] TRACE_SYNC      = 8'hA5;
    localparam int         TRACE_REC_BYTES = 14;
    localparam int         TRACE_FRAME_W   = TRACE_REC_BYTES * 8;

    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int WE_W    = 1;
    localparam int WADDR_W = 5;
    localparam int WDATA_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic               rf_we;
        logic               lost;      // a record was dropped just before this one
        logic [WADDR_W-1:0] rf_waddr;
        logic [WDATA_W-1:0] rf_wdata;  // already zeroed when rf_we is low
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } trace_state_t;

    // Wire order: sync, pc, inst, flags {we, lost, 0, waddr}, wdata.
    function automatic logic [TRACE_FRAME_W-1:0] pack_frame(input trace_rec_t rec);
        return {TRACE_SYNC, rec.pc, rec.inst,
                rec.rf_we, rec.lost, 1'b0, rec.rf_waddr, rec.rf_wdata};
    endfunction

endpackage

// File: rtl/cpu_trace_streamer_if.sv
// Commit bus + byte stream link of the trace streamer.
//   master : streamer view (consumes commits, drives the byte stream)
//   slave  : environment view (CPU retire port and the stream sink)
interface cpu_trace_streamer_if;
    import cpu_trace_pkg::*;

    logic                commit_valid;
    logic [PC_W-1:0]     commit_pc;
    logic [INST_W-1:0]   commit_inst;
    logic                rf_we;
    logic [WADDR_W-1:0]  rf_waddr;
    logic [WDATA_W-1:0]  rf_wdata;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (
        input  commit_valid, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata,
        input  tx_ready,
        output tx_data, tx_valid
    );

    modport slave (
        output commit_valid, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata,
        output tx_ready,
        input  tx_data, tx_valid
    );

endinterface

// File: rtl/cpu_trace_streamer_fifo.sv
// trace_fifo: synchronous FIFO of trace records.
//   clk, reset      : clock, asynchronous active-high reset (pointers/level only)
//   push, wdata     : write request; accepted when not full, or full with pop
//   pop, rdata      : rdata is the head entry, read combinationally so the
//                     serializer can load it on the same edge it pops
//   full, empty     : status flags
//   level           : entries held, 0..DEPTH
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 103
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    // When full, the slot being written is the one being popped this edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg];
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/cpu_trace_streamer.sv
// cpu_trace_streamer: captures one record per retired instruction and streams
// it as 14-byte frames over a valid/ready byte link. Records are buffered in
// trace_fifo so link back-pressure never stalls the CPU; records arriving when
// the FIFO is full (and not popping) are dropped and counted.
//   clk, reset  : clock, asynchronous active-high reset
//   tif         : commit bus in, byte stream out (master modport)
//   overflow    : sticky, a record was dropped since reset
//   drop_cnt    : saturating count of dropped records
//   fifo_level  : records currently buffered (excludes the one being sent)
module cpu_trace_streamer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_trace_streamer_if.master   tif,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);
    trace_state_t             state_reg, state_next;
    logic [TRACE_FRAME_W-1:0] shift_reg;
    logic [3:0]               idx_reg;
    logic                     lost_reg;
    logic                     overflow_reg;
    logic [CNT_W-1:0]         drop_cnt_reg;

    trace_rec_t push_rec;
    trace_rec_t head_rec;
    logic       fifo_full, fifo_empty;
    logic       fifo_push, fifo_pop;
    logic       drop;
    logic       load_frame, shift_frame;

    always_comb begin
        push_rec          = '0;
        push_rec.pc       = tif.commit_pc;
        push_rec.inst     = tif.commit_inst;
        push_rec.rf_we    = tif.rf_we;
        push_rec.lost     = lost_reg;
        push_rec.rf_waddr = tif.rf_waddr;
        push_rec.rf_wdata = tif.rf_we ? tif.rf_wdata : '0;
    end

    assign fifo_push = tif.commit_valid && (!fifo_full || fifo_pop);
    assign drop      = tif.commit_valid && fifo_full && !fifo_pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (TRACE_REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (push_rec),
        .pop   (fifo_pop),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Serializer FSM: next state and per-cycle control.
    always_comb begin
        state_next  = state_reg;
        fifo_pop    = 1'b0;
        load_frame  = 1'b0;
        shift_frame = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_frame = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tif.tx_ready) begin
                    if (idx_reg == 4'(TRACE_REC_BYTES - 1)) begin
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            load_frame = 1'b1;
                        end else begin
                            // Shifting out the last byte leaves tx_data at zero.
                            shift_frame = 1'b1;
                            state_next  = IDLE;
                        end
                    end else begin
                        shift_frame = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            idx_reg      <= '0;
            lost_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_frame) begin
                shift_reg <= pack_frame(head_rec);
                idx_reg   <= '0;
            end else if (shift_frame) begin
                shift_reg <= shift_reg << 8;
                idx_reg   <= idx_reg + 4'd1;
            end
            if (drop) begin
                lost_reg     <= 1'b1;
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != '1) begin
                    drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
                end
            end else if (fifo_push) begin
                lost_reg <= 1'b0;
            end
        end
    end

    assign tif.tx_valid = (state_reg == SEND);
    assign tif.tx_data  = shift_reg[TRACE_FRAME_W-1 -: 8];
    assign overflow     = overflow_reg;
    assign drop_cnt     = drop_cnt_reg;

endmodule

// File: tb/tb_cpu_trace_streamer.sv
module tb_cpu_trace_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [2:0]  fifo_level;

    int checks   = 0;
    int failures = 0;
    logic [7:0] rx[$];

    always #5 clk = ~clk;

    cpu_trace_streamer_if tif();

    cpu_trace_streamer #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tif        (tif.master),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tif.commit_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Reference frame built from the field layout: sync, pc, inst, flags, wdata.
    function automatic logic [111:0] make_frame(input logic [31:0] pc, input logic [31:0] inst,
                                                input logic we, input logic lost,
                                                input logic [4:0] waddr, input logic [31:0] wdata);
        return {8'hA5, pc, inst, we, lost, 1'b0, waddr, (we ? wdata : 32'h0)};
    endfunction

    function automatic logic [31:0] rec_pc(input int i);    return 32'h0040_0000 + 32'(i * 4); endfunction
    function automatic logic [31:0] rec_inst(input int i);  return 32'h2000_0000 | 32'(i);     endfunction
    function automatic logic        rec_we(input int i);    return ((i % 2) == 0);             endfunction
    function automatic logic [4:0]  rec_waddr(input int i); return 5'(i + 3);                  endfunction
    function automatic logic [31:0] rec_wdata(input int i); return 32'hDEAD_0000 + 32'(i);     endfunction

    function automatic logic [111:0] rec_frame(input int i, input logic lost);
        return make_frame(rec_pc(i), rec_inst(i), rec_we(i), lost, rec_waddr(i), rec_wdata(i));
    endfunction

    task automatic drive_rec(input int i);
        tif.commit_valid = 1'b1;
        tif.commit_pc    = rec_pc(i);
        tif.commit_inst  = rec_inst(i);
        tif.rf_we        = rec_we(i);
        tif.rf_waddr     = rec_waddr(i);
        tif.rf_wdata     = rec_wdata(i);
    endtask

    task automatic commit_rec(input int i);
        drive_rec(i);
        step();
        tif.commit_valid = 1'b0;
    endtask

    task automatic commit_t1();
        tif.commit_valid = 1'b1;
        tif.commit_pc    = 32'h0040_0000;
        tif.commit_inst  = 32'h3C01_0000;
        tif.rf_we        = 1'b1;
        tif.rf_waddr     = 5'd1;
        tif.rf_wdata     = 32'h1001_0000;
        step();
        tif.commit_valid = 1'b0;
    endtask

    // Receive nbytes from the link; with toggle, tx_ready alternates 1,0,1,...
    // and a stalled byte must stay put until it is accepted.
    task automatic collect(input int nbytes, input bit toggle);
        int         cyc = 0;
        bit         rdy = 1'b1;
        bit         held;
        logic [7:0] hd;
        rx.delete();
        while (rx.size() < nbytes && cyc < 4 * nbytes + 20) begin
            tif.tx_ready = toggle ? rdy : 1'b1;
            held = tif.tx_valid && !tif.tx_ready;
            hd   = tif.tx_data;
            if (tif.tx_valid && tif.tx_ready) rx.push_back(tif.tx_data);
            step();
            cyc++;
            if (held) begin
                chk("hold_valid", 32'(tif.tx_valid), 32'd1);
                chk("hold_data", 32'(tif.tx_data), 32'(hd));
            end
            rdy = !rdy;
        end
        if (rx.size() < nbytes) chk("collect_timeout", rx.size(), nbytes);
    endtask

    task automatic chk_frame(input string tag, input int base, input logic [111:0] f);
        logic [31:0] obs;
        for (int i = 0; i < 14; i++) begin
            obs = 'x;
            if (base + i < rx.size()) obs = 32'(rx[base + i]);
            chk($sformatf("%s_b%0d", tag, i), obs, 32'(f[111 - 8 * i -: 8]));
        end
        $display("frame %s checked from byte %0d", tag, base);
    endtask

    localparam logic [111:0] T1_FRAME = 112'hA5_00400000_3C010000_81_10010000;

    initial begin
        tif.commit_valid = 1'b0;
        tif.commit_pc    = '0;
        tif.commit_inst  = '0;
        tif.rf_we        = 1'b0;
        tif.rf_waddr     = '0;
        tif.rf_wdata     = '0;
        tif.tx_ready     = 1'b0;

        // Reset state
        do_reset();
        chk("rst_tx_valid", 32'(tif.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tif.tx_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);

        // 1: single record, sink always ready; tx_valid rises one edge after commit
        tif.tx_ready = 1'b1;
        commit_t1();
        chk("t1_lat_n", 32'(tif.tx_valid), 32'd0);
        chk("t1_level_n", 32'(fifo_level), 32'd1);
        step();
        chk("t1_lat_n1", 32'(tif.tx_valid), 32'd1);
        chk("t1_sync", 32'(tif.tx_data), 32'hA5);
        collect(14, 1'b0);
        chk_frame("t1", 0, T1_FRAME);
        chk("t1_end_valid", 32'(tif.tx_valid), 32'd0);

        // 2: same record with tx_ready toggling
        commit_t1();
        step();
        collect(14, 1'b1);
        chk_frame("t2", 0, T1_FRAME);
        chk("t2_rx_count", rx.size(), 14);
        step();
        chk("t2_end_valid", 32'(tif.tx_valid), 32'd0);

        // 3: stalled sink, 7 back-to-back commits: 1 in shifter, 4 buffered, 2 dropped
        do_reset();
        tif.tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_rec(i);
            step();
        end
        tif.commit_valid = 1'b0;
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_level", 32'(fifo_level), 32'd4);
        chk("t3_sync_held", 32'(tif.tx_data), 32'hA5);
        collect(70, 1'b0);
        for (int r = 0; r < 5; r++) chk_frame($sformatf("t3_rec%0d", r), 14 * r, rec_frame(r, 1'b0));
        chk("t3_drained_valid", 32'(tif.tx_valid), 32'd0);
        chk("t3_drained_level", 32'(fifo_level), 32'd0);
        commit_rec(7);
        commit_rec(8);
        collect(28, 1'b0);
        chk_frame("t3_rec7_lost", 0, rec_frame(7, 1'b1));
        chk_frame("t3_rec8", 14, rec_frame(8, 1'b0));
        chk("t3_drop_kept", 32'(drop_cnt), 32'd2);

        // 4: FIFO full, commit on the edge that transfers the final byte
        do_reset();
        tif.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rec(i);
            step();
        end
        tif.commit_valid = 1'b0;
        chk("t4_full_level", 32'(fifo_level), 32'd4);
        collect(13, 1'b0);
        chk("t4_last_byte", 32'(tif.tx_data), 32'(rec_frame(0, 1'b0) & 112'hFF));
        drive_rec(9);
        tif.tx_ready = 1'b1;
        step();
        tif.commit_valid = 1'b0;
        chk("t4_level_same", 32'(fifo_level), 32'd4);
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_b2b_valid", 32'(tif.tx_valid), 32'd1);
        chk("t4_b2b_sync", 32'(tif.tx_data), 32'hA5);
        collect(70, 1'b0);
        chk_frame("t4_rec1", 0, rec_frame(1, 1'b0));
        chk_frame("t4_rec9", 56, rec_frame(9, 1'b0));

        // 5: asynchronous reset in the middle of a record
        do_reset();
        tif.tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_rec(i);
            step();
        end
        tif.commit_valid = 1'b0;
        collect(5, 1'b0);
        tif.tx_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t5_valid", 32'(tif.tx_valid), 32'd0);
        chk("t5_data", 32'(tif.tx_data), 32'd0);
        chk("t5_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_level", 32'(fifo_level), 32'd0);
        step();
        reset = 1'b0;
        tif.tx_ready = 1'b1;
        commit_rec(10);
        step();
        chk("t5_restart_sync", 32'(tif.tx_data), 32'hA5);
        collect(14, 1'b0);
        chk_frame("t5_rec10", 0, rec_frame(10, 1'b0));

        // 6: drop counter saturation
        do_reset();
        tif.tx_ready = 1'b0;
        drive_rec(11);
        // 5 accepted edges, every later edge drops one record
        for (int i = 0; i < 65539; i++) step();
        chk("t6_fffe", 32'(drop_cnt), 32'hFFFE);
        step();
        chk("t6_ffff", 32'(drop_cnt), 32'hFFFF);
        step();
        step();
        chk("t6_nowrap", 32'(drop_cnt), 32'hFFFF);
        chk("t6_overflow", 32'(overflow), 32'd1);
        chk("t6_level", 32'(fifo_level), 32'd4);
        tif.commit_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
